// File: rtl/fp_pkg.sv
// Shared types and helpers for the multi-cycle floating-point multiplier.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, only the mantissa MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction

endpackage

// File: rtl/fp_classify_p.sv
// Combinational classification of one operand's exponent/mantissa fields.
module fp_classify_p #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W-1:0] mag,
    output logic                   snan,
    output logic                   qnan,
    output logic                   inf,
    output logic                   zero,
    output logic                   subnormal,
    output logic                   normal
);

    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] frac;
    logic             exp_ones;
    logic             exp_zero;
    logic             frac_zero;

    assign expo      = mag[EXP_W+MAN_W-1:MAN_W];
    assign frac      = mag[MAN_W-1:0];
    assign exp_ones  = &expo;
    assign exp_zero  = ~|expo;
    assign frac_zero = ~|frac;

    assign snan      = exp_ones & ~frac_zero & ~frac[MAN_W-1];
    assign qnan      = exp_ones & frac[MAN_W-1];
    assign inf       = exp_ones & frac_zero;
    assign zero      = exp_zero & frac_zero;
    assign subnormal = exp_zero & ~frac_zero;
    assign normal    = ~exp_ones & ~exp_zero;

endmodule

// File: rtl/fp_mul_multicycle.sv
// Multi-cycle floating-point multiplier: shift-add mantissa product, RNE rounding,
// DAZ/FTZ, start/busy/done handshake.
//
//  state  | meaning
//  IDLE   | waiting for start; operands latched on acceptance
//  UNPACK | classify operands, resolve specials, seed datapath
//  MUL    | one multiplier bit per cycle, LSB first
//  NORM   | align product so the leading 1 sits below the MSB
//  ROUND  | round to nearest even, overflow/underflow, pack
//  DONE   | result valid, done pulse
module fp_mul_multicycle
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int PW = 2 * M;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(M + 1);

    localparam logic [63:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];
    localparam logic signed [EW-1:0] E_BIAS    = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO    = '0;
    localparam logic [CW-1:0]        CNT_INIT  = CW'(M);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(1);

    state_t state, state_nxt;

    logic [W-1:0]         op_a, op_b;
    logic                 sign;
    logic signed [EW-1:0] e;
    logic [PW-1:0]        mcand;
    logic [M-1:0]         mplier;
    logic [PW-1:0]        prod;
    logic                 sticky_lo;
    logic [CW-1:0]        cnt;

    logic snan_a, qnan_a, inf_a, zero_a, sub_a, norm_a;
    logic snan_b, qnan_b, inf_b, zero_b, sub_b, norm_b;

    fp_classify_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .mag      (op_a[W-2:0]),
        .snan     (snan_a),
        .qnan     (qnan_a),
        .inf      (inf_a),
        .zero     (zero_a),
        .subnormal(sub_a),
        .normal   (norm_a)
    );

    fp_classify_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .mag      (op_b[W-2:0]),
        .snan     (snan_b),
        .qnan     (qnan_b),
        .inf      (inf_b),
        .zero     (zero_b),
        .subnormal(sub_b),
        .normal   (norm_b)
    );

    logic         sign_ab;
    logic         flush_a, flush_b;
    logic         spec_hit;
    logic         spec_nan;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;

    assign sign_ab = op_a[W-1] ^ op_b[W-1];
    assign flush_a = zero_a | sub_a;
    assign flush_b = zero_b | sub_b;
    assign spec_hit = ~(norm_a & norm_b);

    always_comb begin
        spec_nan = 1'b0;
        spec_res = '0;
        if (snan_a) begin
            spec_nan = 1'b1;
            spec_res = op_a;
            spec_res[MAN_W-1] = 1'b1;
        end else if (snan_b) begin
            spec_nan = 1'b1;
            spec_res = op_b;
            spec_res[MAN_W-1] = 1'b1;
        end else if (qnan_a) begin
            spec_nan = 1'b1;
            spec_res = op_a;
        end else if (qnan_b) begin
            spec_nan = 1'b1;
            spec_res = op_b;
        end else if ((inf_a & flush_b) | (inf_b & flush_a)) begin
            spec_nan = 1'b1;
            spec_res = QNAN;
        end else if (inf_a | inf_b) begin
            spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_res = {sign_ab, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        spec_flags = '0;
        if (!spec_nan) begin
            spec_flags[FLG_N] = spec_res[W-1];
            spec_flags[FLG_Z] = ~|spec_res[W-2:0];
        end
    end

    logic [M-1:0]         man_n;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [M:0]           sum;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_r;
    logic [W-1:0]         rnd_res;
    logic [3:0]           rnd_flags;

    // Leading 1 of the normalised product sits at bit 2*MAN_W.
    always_comb begin
        man_n  = prod[2*MAN_W:MAN_W];
        guard  = prod[MAN_W-1];
        sticky = (|prod[MAN_W-2:0]) | sticky_lo;
        inc    = guard & (sticky | man_n[0]);
        sum    = {1'b0, man_n} + {{M{1'b0}}, inc};
        frac   = sum[M] ? sum[MAN_W:1] : sum[MAN_W-1:0];
        e_r    = sum[M] ? e + E_ONE : e;

        rnd_res          = '0;
        rnd_flags        = '0;
        rnd_flags[FLG_N] = sign;
        if (e_r >= E_MAX) begin
            rnd_res          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags[FLG_C] = 1'b1;
            rnd_flags[FLG_V] = 1'b1;
        end else if (e_r <= E_ZERO) begin
            rnd_res          = {sign, {(W-1){1'b0}}};
            rnd_flags[FLG_Z] = 1'b1;
            rnd_flags[FLG_C] = 1'b1;
        end else begin
            rnd_res          = {sign, e_r[EXP_W-1:0], frac};
            rnd_flags[FLG_C] = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = spec_hit ? DONE : MUL;
            MUL:     if (cnt == CNT_LAST) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a      <= '0;
            op_b      <= '0;
            sign      <= 1'b0;
            e         <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            sticky_lo <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            flags     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= a;
                        op_b <= b;
                    end
                end
                UNPACK: begin
                    sign      <= sign_ab;
                    e         <= $signed({2'b00, op_a[W-2:MAN_W]})
                               + $signed({2'b00, op_b[W-2:MAN_W]}) - E_BIAS;
                    mcand     <= PW'({1'b1, op_a[MAN_W-1:0]});
                    mplier    <= {1'b1, op_b[MAN_W-1:0]};
                    prod      <= '0;
                    sticky_lo <= 1'b0;
                    cnt       <= CNT_INIT;
                    if (spec_hit) begin
                        result <= spec_res;
                        flags  <= spec_flags;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_LAST;
                end
                NORM: begin
                    if (prod[PW-1]) begin
                        prod      <= prod >> 1;
                        sticky_lo <= prod[0];
                        e         <= e + E_ONE;
                    end
                end
                ROUND: begin
                    result <= rnd_res;
                    flags  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_multicycle.sv
// Randomised + directed bench for fp_mul_multicycle (half and single precision instances).
module tb_fp_mul_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start_h, start_s;
    logic [15:0] a_h, b_h, res_h;
    logic [31:0] a_s, b_s, res_s;
    logic        busy_h, done_h, busy_s, done_s;
    logic [3:0]  flg_h, flg_s;

    fp_mul_multicycle #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .reset(reset), .start(start_h), .a(a_h), .b(b_h),
        .busy(busy_h), .done(done_h), .result(res_h), .flags(flg_h)
    );

    fp_mul_multicycle #(.EXP_W(8), .MAN_W(23)) u_single (
        .clk(clk), .reset(reset), .start(start_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .result(res_s), .flags(flg_s)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          finish_req = 1'b0;
    logic [43:0] q_h[$];
    logic [43:0] q_s[$];
    bit          infl[2];
    int          acc_cyc[2];

    // Expectation record: {latency[7:0], flags[3:0], result[31:0]}
    function automatic logic [43:0] mk(input int lat, input logic [3:0] f, input logic [31:0] r);
        return {lat[7:0], f, r};
    endfunction

    // Reference product computed from exact integer arithmetic on the significands.
    function automatic logic [43:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned emax, fmask, qb, fa, fb, ea, eb, ma, mb, p, q, rem, half, r, sgl;
        int  sh, e, bias;
        logic sg, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
        logic [3:0] fl;
        int lat;
        emax  = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << mw) - 64'd1;
        qb    = 64'd1 << (mw - 1);
        bias  = (1 << (ew - 1)) - 1;
        fa = 64'(a) & fmask;
        fb = 64'(b) & fmask;
        ea = (64'(a) >> mw) & emax;
        eb = (64'(b) >> mw) & emax;
        sg = a[ew+mw] ^ b[ew+mw];
        sgl = 64'(sg) << (ew + mw);
        nan_a  = (ea == emax) && (fa != 0);
        nan_b  = (eb == emax) && (fb != 0);
        snan_a = nan_a && ((fa & qb) == 0);
        snan_b = nan_b && ((fb & qb) == 0);
        inf_a  = (ea == emax) && (fa == 0);
        inf_b  = (eb == emax) && (fb == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        lat = 2;
        fl  = 4'b0000;
        if (snan_a)      r = 64'(a) | qb;
        else if (snan_b) r = 64'(b) | qb;
        else if (nan_a)  r = 64'(a);
        else if (nan_b)  r = 64'(b);
        else if ((inf_a && zero_b) || (inf_b && zero_a)) r = (emax << mw) | qb;
        else if (inf_a || inf_b) begin
            r  = sgl | (emax << mw);
            fl = {sg, 3'b000};
        end else if (zero_a || zero_b) begin
            r  = sgl;
            fl = {sg, 3'b100};
        end else begin
            lat = mw + 5;
            ma = fa | (64'd1 << mw);
            mb = fb | (64'd1 << mw);
            p  = ma * mb;
            sh = (p >= (64'd1 << (2 * mw + 1))) ? mw + 1 : mw;
            e  = int'(ea) + int'(eb) - bias + (sh - mw);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << (mw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= int'(emax)) begin
                r  = sgl | (emax << mw);
                fl = {sg, 3'b011};
            end else if (e <= 0) begin
                r  = sgl;
                fl = {sg, 3'b110};
            end else begin
                r  = sgl | (64'(e) << mw) | (q & fmask);
                fl = {sg, 1'b0, (rem != 0), 1'b0};
            end
        end
        return mk(lat, fl, r[31:0]);
    endfunction

    function automatic logic [31:0] rnd_norm(input int ew, input int mw);
        int bias, ex;
        bias = (1 << (ew - 1)) - 1;
        if ($urandom_range(0, 3) == 0) ex = int'($urandom_range(1, (1 << ew) - 2));
        else                           ex = bias - bias / 2 + int'($urandom_range(0, bias));
        return (32'($urandom_range(0, 1)) << (ew + mw)) | (32'(ex) << mw)
             | ($urandom & ((32'd1 << mw) - 32'd1));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    logic        bz, dn, st;
    logic [31:0] rs;
    logic [3:0]  fg;
    logic [43:0] ev;

    // Single compare process: every cycle, both DUTs.
    always @(negedge clk) begin
        cyc++;
        if (cyc == 1) begin
            chk("pin_one",      ref_mul(5, 10, 32'h3C00, 32'h3C00), mk(15, 4'b0000, 32'h3C00));
            chk("pin_neg",      ref_mul(5, 10, 32'h4000, 32'hC200), mk(15, 4'b1000, 32'hC600));
            chk("pin_inexact",  ref_mul(5, 10, 32'h3C01, 32'h3C01), mk(15, 4'b0010, 32'h3C02));
            chk("pin_tie_up",   ref_mul(5, 10, 32'h3C01, 32'h3E00), mk(15, 4'b0010, 32'h3E02));
            chk("pin_tie_even", ref_mul(5, 10, 32'h3C03, 32'h3E00), mk(15, 4'b0010, 32'h3E04));
            chk("pin_ovf",      ref_mul(5, 10, 32'h7BFF, 32'h7BFF), mk(15, 4'b0011, 32'h7C00));
            chk("pin_unf",      ref_mul(5, 10, 32'h0400, 32'h0400), mk(15, 4'b0110, 32'h0000));
            chk("pin_inf0",     ref_mul(5, 10, 32'h7C00, 32'h0000), mk(2, 4'b0000, 32'h7E00));
            chk("pin_snan",     ref_mul(5, 10, 32'h7D00, 32'h3C00), mk(2, 4'b0000, 32'h7F00));
            chk("pin_single",   ref_mul(8, 23, 32'h3F800000, 32'h40000000),
                                mk(28, 4'b0000, 32'h40000000));
        end
        for (int d = 0; d < 2; d++) begin
            bz = (d == 1) ? busy_s  : busy_h;
            dn = (d == 1) ? done_s  : done_h;
            st = (d == 1) ? start_s : start_h;
            rs = (d == 1) ? res_s   : {16'h0000, res_h};
            fg = (d == 1) ? flg_s   : flg_h;
            if (!reset) begin
                chk("reset_busy",   64'(bz), 64'(0));
                chk("reset_done",   64'(dn), 64'(0));
                chk("reset_result", 64'(rs), 64'(0));
                chk("reset_flags",  64'(fg), 64'(0));
                infl[d] = 1'b0;
            end else begin
                chk("busy", 64'(bz), 64'(infl[d]));
                if (dn) begin
                    if (!infl[d]) begin
                        n_checks++;
                        $display("FAIL spurious_done dut%0d: got done=1 required done=0 (cycle %0d)", d, cyc);
                    end else if ((d == 1 ? q_s.size() : q_h.size()) == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done dut%0d: got done=1 required no result pending", d);
                    end else begin
                        ev = (d == 1) ? q_s.pop_front() : q_h.pop_front();
                        chk("result",  64'(rs), 64'(ev[31:0]));
                        chk("flags",   64'(fg), 64'(ev[35:32]));
                        chk("latency", 64'(cyc - acc_cyc[d]), 64'(ev[43:36]));
                    end
                    infl[d] = 1'b0;
                end else if (infl[d] && (cyc - acc_cyc[d] > 64)) begin
                    n_checks++;
                    $display("FAIL timeout dut%0d: got no done after %0d cycles required done", d, cyc - acc_cyc[d]);
                    infl[d] = 1'b0;
                end else if (st && !infl[d]) begin
                    infl[d]    = 1'b1;
                    acc_cyc[d] = cyc;
                end
            end
        end
        if (finish_req || cyc > 60000) begin
            if (cyc > 60000) begin
                n_checks++;
                $display("FAIL watchdog: got cycle %0d required completion", cyc);
            end
            chk("pending_half",   64'(q_h.size()), 64'(0));
            chk("pending_single", 64'(q_s.size()), 64'(0));
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    task automatic wait_done(input int d);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if ((d == 1) ? done_s : done_h) break;
        end
    endtask

    task automatic op_h(input logic [15:0] x, input logic [15:0] y, input logic [43:0] exp);
        @(posedge clk); #1;
        q_h.push_back(exp);
        a_h = x; b_h = y; start_h = 1'b1;
        @(posedge clk); #1;
        start_h = 1'b0;
        wait_done(0);
    endtask

    task automatic op_s(input logic [31:0] x, input logic [31:0] y, input logic [43:0] exp);
        @(posedge clk); #1;
        q_s.push_back(exp);
        a_s = x; b_s = y; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        wait_done(1);
    endtask

    logic [15:0] pool[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                             16'h7E00, 16'h7D00, 16'h0001, 16'h83FF};
    logic [15:0] x16, y16;
    logic [31:0] x32, y32;

    initial begin
        start_h = 1'b0; start_s = 1'b0;
        a_h = '0; b_h = '0; a_s = '0; b_s = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        op_h(16'h3C00, 16'h3C00, mk(15, 4'b0000, 32'h3C00));
        op_h(16'h4000, 16'hC200, mk(15, 4'b1000, 32'hC600));
        op_h(16'h3C01, 16'h3C01, mk(15, 4'b0010, 32'h3C02));
        op_h(16'h3C00, 16'h3C01, mk(15, 4'b0000, 32'h3C01));
        op_h(16'h3C01, 16'h3E00, mk(15, 4'b0010, 32'h3E02));
        op_h(16'h3C03, 16'h3E00, mk(15, 4'b0010, 32'h3E04));
        op_h(16'h7BFF, 16'h7BFF, mk(15, 4'b0011, 32'h7C00));
        op_h(16'h0400, 16'h0400, mk(15, 4'b0110, 32'h0000));
        op_h(16'h7C00, 16'h0000, mk(2,  4'b0000, 32'h7E00));
        op_h(16'h7D00, 16'h3C00, mk(2,  4'b0000, 32'h7F00));
        op_h(16'h0001, 16'h3C00, mk(2,  4'b0100, 32'h0000));
        op_h(16'hFC00, 16'h3C00, mk(2,  4'b1000, 32'hFC00));
        op_h(16'h8000, 16'h3C00, mk(2,  4'b1100, 32'h8000));

        // start while busy with different operands, and operand changes after acceptance
        @(posedge clk); #1;
        q_h.push_back(mk(15, 4'b0010, 32'h3C02));
        a_h = 16'h3C01; b_h = 16'h3C01; start_h = 1'b1;
        @(posedge clk); #1;
        start_h = 1'b0; a_h = 16'h7BFF; b_h = 16'h7BFF;
        repeat (3) @(posedge clk);
        #1 start_h = 1'b1;
        @(posedge clk); #1 start_h = 1'b0;
        wait_done(0);
        repeat (20) @(posedge clk);

        // reset in the middle of MUL discards the operation
        #1 a_h = 16'h4000; b_h = 16'h4000; start_h = 1'b1;
        @(posedge clk); #1 start_h = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (25) @(posedge clk);
        op_h(16'h4000, 16'h4200, mk(15, 4'b0000, 32'h4600));

        op_s(32'h3F800000, 32'h40000000, mk(28, 4'b0000, 32'h40000000));
        op_s(32'hC0400000, 32'h40400000, mk(28, 4'b1000, 32'hC1100000));

        for (int i = 0; i < 40; i++) begin
            x16 = 16'(rnd_norm(5, 10));
            y16 = 16'(rnd_norm(5, 10));
            op_h(x16, y16, ref_mul(5, 10, {16'h0000, x16}, {16'h0000, y16}));
        end
        for (int i = 0; i < 20; i++) begin
            x16 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            y16 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            op_h(x16, y16, ref_mul(5, 10, {16'h0000, x16}, {16'h0000, y16}));
        end
        for (int i = 0; i < 40; i++) begin
            x32 = rnd_norm(8, 23);
            y32 = rnd_norm(8, 23);
            op_s(x32, y32, ref_mul(8, 23, x32, y32));
        end

        repeat (5) @(posedge clk);
        finish_req = 1'b1;
    end

endmodule
